id_stage_pipe: RTL and testbench
================================

// Module: id_stage_pipe
// PURPOSE
//  Parametrised decode stage for GeMIPS: decodes one instruction, reads the register file, and forwards from FWD_N later stages.
//  Detects load-use hazards and stalls on them. Owns the ID/EX pipeline register with a valid/ready handshake.
//  Tracks branch delay slots internally. Sits between the IF stage and the EX stage.
// PARAMETERS
//  DATA_W  32  datapath / register width
//  ADDR_W   5  register-file address width
//  FWD_N    3  number of forwarding sources; index 0 = youngest (EX), highest = oldest
// PORTS
//  clk          in   1               clock
//  rst          in   1               synchronous active-high reset
//  in_valid     in   1               IF presents pc/inst
//  in_ready     out  1               ID accepts this cycle
//  pc           in   DATA_W          instruction address
//  inst         in   32              instruction word
//  raddr_1/2    out  ADDR_W          RF read addresses
//  re_1/2       out  1               RF read enables
//  rdata_1/2    in   DATA_W          RF read data
//  fwd_we       in   FWD_N           per-source write enable
//  fwd_waddr    in   FWD_N*ADDR_W    per-source dest (packed; src j at [j*ADDR_W+:ADDR_W])
//  fwd_wdata    in   FWD_N*DATA_W    per-source data (packed likewise)
//  fwd_is_load  in   FWD_N           source data not yet valid (load in flight)
//  out_valid    out  1               ID/EX register holds an instruction
//  out_ready    in   1               EX consumes this cycle
//  aluop        out  8               ALU sub-op (registered)
//  alusel       out  4               ALU select (registered)
//  reg_1/reg_2  out  DATA_W          operands (registered)
//  waddr / we   out  ADDR_W / 1      destination and enable (registered)
//  inst_o       out  32              instruction, passed on for EX address calc (registered)
//  link_addr_o  out  DATA_W          pc+8 for JAL (registered)
//  is_in_delayslot_o  out  1         instruction is in a delay slot (registered)
//  branch_flag_o      out  1         redirect IF; combinational, asserted only in the accept cycle
//  target_address_o   out  DATA_W    redirect target; 0 when branch_flag_o=0
//  stall_cnt_o        out  32        count of load-use stall cycles
// BEHAVIOUR
//  - Reset: all registered outputs and stall_cnt_o go to 0; out_valid=0; delay-slot flag=0. Reset mid-handshake drops the held instruction.
//  - Accept: acc = in_valid & in_ready. in_ready = (!out_valid | out_ready) & !hazard.
//  - On acc, the ID/EX register loads the decode results at the next edge; latency is 1 cycle.
//  - When out_ready=1 and !acc, out_valid falls to 0 (bubble). When out_valid=1 and out_ready=0, the register holds.
//  - Hazard: re_k=1, raddr_k!=0, and some source j has fwd_we[j] & fwd_is_load[j] & waddr_j==raddr_k.
//    Only the youngest matching source counts. While hazard=1 with in_valid=1, stall_cnt_o increments (wraps at 2^32).
//  - Forwarding per operand: the lowest-index matching source wins, then rdata. raddr 0 always yields 0 and is never forwarded.
//  - When re_k=0, the operand is: sa zero-extended (SLL/SRL), imm sign-extended (ADDIU, LB, LW, SW, SB), or imm zero-extended (ANDI, ORI, XORI, LUI).
//  - Branches: BEQ/BNE compare reg_1 vs reg_2. BGTZ uses a signed compare, reg_1>0.
//    Target for all conditional branches = pc+4+sext(offset<<2). J/JAL target = {pc[31:28], index, 2'b00}. JR target = reg_1.
//  - Delay slot: accepting any J/JAL/JR/BEQ/BNE/BGTZ (taken or not) sets the flag. The next accepted instruction carries is_in_delayslot_o=1 and clears the flag.
//    If a branch is accepted while the flag is set, the flag stays set.
//  - Writes: R-type (except JR), MUL, JAL (waddr=31), and immediate ALU/loads (waddr=rt). Undecoded opcodes give we=0 and aluop NOP.
// CONFIGURATION
//  GEMIPS_ID_REGIMM_EN defined:
//    - adds REGIMM (op 000001) decode: BLTZ, BGEZ, BLTZAL, BGEZAL, all signed on reg_1.
//    - BLTZAL/BGEZAL write r31 with pc+8 whether taken or not, and set the delay-slot flag.
//  GEMIPS_ID_REGIMM_EN undefined:
//    - op 000001 decodes as NOP: we=0, no branch, no flag change.
// STRUCTURE
//  - gemips_pkg holds: opcode/func constants, ALU_OP_* / ALU_SEL_* codes, and a localparam list of branch opcodes.
//  - Sub-module id_fwd_mux (params DATA_W, ADDR_W, FWD_N) does priority forwarding plus the load-hit flag. It is instantiated once per operand.
// TESTING
//  - ADDU r3,r1,r2 with rdata 5/7 and no fwd hits -> next cycle out_valid=1, reg_1=5, reg_2=7, waddr=3, we=1.
//  - fwd0 writes r1=0xAA and fwd2 writes r1=0xBB together -> reg_1=0xAA. A fwd hit on r0 -> reg_1=0.
//  - fwd_is_load[0]=1 on r1 while ORI r2,r1,1 is presented -> in_ready=0 for 1 cycle, stall_cnt_o=1.
//    The next cycle has no load -> accept, reg_2=1.
//  - BGTZ with reg_1=0xFFFFFFFF -> branch_flag_o=0, but the next accepted instruction has is_in_delayslot_o=1.
//  - out_ready=0 for 3 cycles with out_valid=1 -> outputs held, in_ready=0. rst asserted mid-hold -> out_valid=0 next cycle.
//  - With GEMIPS_ID_REGIMM_EN: BGEZAL, reg_1=0, pc=0x100 -> branch to 0x104+off, link 0x108, waddr=31.

Source files
------------

// File: rtl/gemips_pkg.sv
// Shared GeMIPS decode constants: opcodes, function codes, ALU op/select codes,
// branch-kind enum and the list of opcodes that open a delay slot.
package gemips_pkg;

   localparam logic [5:0] OP_SPECIAL  = 6'b000000;
   localparam logic [5:0] OP_REGIMM   = 6'b000001;
   localparam logic [5:0] OP_J        = 6'b000010;
   localparam logic [5:0] OP_JAL      = 6'b000011;
   localparam logic [5:0] OP_BEQ      = 6'b000100;
   localparam logic [5:0] OP_BNE      = 6'b000101;
   localparam logic [5:0] OP_BGTZ     = 6'b000111;
   localparam logic [5:0] OP_ADDIU    = 6'b001001;
   localparam logic [5:0] OP_ANDI     = 6'b001100;
   localparam logic [5:0] OP_ORI      = 6'b001101;
   localparam logic [5:0] OP_XORI     = 6'b001110;
   localparam logic [5:0] OP_LUI      = 6'b001111;
   localparam logic [5:0] OP_SPECIAL2 = 6'b011100;
   localparam logic [5:0] OP_LB       = 6'b100000;
   localparam logic [5:0] OP_LW       = 6'b100011;
   localparam logic [5:0] OP_SB       = 6'b101000;
   localparam logic [5:0] OP_SW       = 6'b101011;

   localparam logic [5:0] F_SLL  = 6'b000000;
   localparam logic [5:0] F_SRL  = 6'b000010;
   localparam logic [5:0] F_JR   = 6'b001000;
   localparam logic [5:0] F_ADDU = 6'b100001;
   localparam logic [5:0] F_SUBU = 6'b100011;
   localparam logic [5:0] F_AND  = 6'b100100;
   localparam logic [5:0] F_OR   = 6'b100101;
   localparam logic [5:0] F_XOR  = 6'b100110;
   localparam logic [5:0] F_NOR  = 6'b100111;
   localparam logic [5:0] F_SLT  = 6'b101010;
   localparam logic [5:0] F_MUL  = 6'b000010;

   localparam logic [4:0] RT_BLTZ   = 5'b00000;
   localparam logic [4:0] RT_BGEZ   = 5'b00001;
   localparam logic [4:0] RT_BLTZAL = 5'b10000;
   localparam logic [4:0] RT_BGEZAL = 5'b10001;

   localparam logic [7:0] ALU_OP_NOP    = 8'h00;
   localparam logic [7:0] ALU_OP_AND    = 8'h24;
   localparam logic [7:0] ALU_OP_OR     = 8'h25;
   localparam logic [7:0] ALU_OP_XOR    = 8'h26;
   localparam logic [7:0] ALU_OP_NOR    = 8'h27;
   localparam logic [7:0] ALU_OP_LUI    = 8'h5C;
   localparam logic [7:0] ALU_OP_SLL    = 8'h7C;
   localparam logic [7:0] ALU_OP_SRL    = 8'h02;
   localparam logic [7:0] ALU_OP_SLT    = 8'h2A;
   localparam logic [7:0] ALU_OP_ADDU   = 8'h21;
   localparam logic [7:0] ALU_OP_SUBU   = 8'h23;
   localparam logic [7:0] ALU_OP_MUL    = 8'hA9;
   localparam logic [7:0] ALU_OP_J      = 8'h4F;
   localparam logic [7:0] ALU_OP_JAL    = 8'h50;
   localparam logic [7:0] ALU_OP_JR     = 8'h08;
   localparam logic [7:0] ALU_OP_BEQ    = 8'h51;
   localparam logic [7:0] ALU_OP_BNE    = 8'h52;
   localparam logic [7:0] ALU_OP_BGTZ   = 8'h54;
   localparam logic [7:0] ALU_OP_BLTZ   = 8'h40;
   localparam logic [7:0] ALU_OP_BGEZ   = 8'h41;
   localparam logic [7:0] ALU_OP_BLTZAL = 8'h4A;
   localparam logic [7:0] ALU_OP_BGEZAL = 8'h4B;
   localparam logic [7:0] ALU_OP_LB     = 8'hE0;
   localparam logic [7:0] ALU_OP_LW     = 8'hE3;
   localparam logic [7:0] ALU_OP_SB     = 8'hE8;
   localparam logic [7:0] ALU_OP_SW     = 8'hEB;

   localparam logic [3:0] ALU_SEL_NOP       = 4'd0;
   localparam logic [3:0] ALU_SEL_LOGIC     = 4'd1;
   localparam logic [3:0] ALU_SEL_SHIFT     = 4'd2;
   localparam logic [3:0] ALU_SEL_ARITH     = 4'd4;
   localparam logic [3:0] ALU_SEL_MUL       = 4'd5;
   localparam logic [3:0] ALU_SEL_JUMP      = 4'd6;
   localparam logic [3:0] ALU_SEL_LOADSTORE = 4'd7;

   typedef enum logic [2:0] {
      BR_NONE, BR_J, BR_JR, BR_EQ, BR_NE, BR_GTZ, BR_LTZ, BR_GEZ
   } br_kind_e;

   // Primary opcodes that open a delay slot; JR and REGIMM are recognised by sub-field.
   localparam int N_BRANCH_OPS = 5;
   localparam logic [5:0] BRANCH_OPS [N_BRANCH_OPS] = '{OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BGTZ};

   function automatic logic is_branch_op(input logic [5:0] op);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < N_BRANCH_OPS; i++) begin
         if (op == BRANCH_OPS[i]) hit = 1'b1;
      end
      return hit;
   endfunction

endpackage

// File: rtl/id_fwd_mux.sv
// Priority forwarding for one operand: lowest-index matching source wins over RF data.
// load_hit_o flags that the youngest match is a load whose data is not yet available.
module id_fwd_mux
   import gemips_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int FWD_N  = 3
) (
   input  logic                      re_i,
   input  logic [ADDR_W-1:0]         raddr_i,
   input  logic [DATA_W-1:0]         rdata_i,
   input  logic [FWD_N-1:0]          fwd_we_i,
   input  logic [FWD_N*ADDR_W-1:0]   fwd_waddr_i,
   input  logic [FWD_N*DATA_W-1:0]   fwd_wdata_i,
   input  logic [FWD_N-1:0]          fwd_is_load_i,
   output logic [DATA_W-1:0]         data_o,
   output logic                      load_hit_o
);

   always_comb begin
      data_o     = rdata_i;
      load_hit_o = 1'b0;
      // Walk oldest to youngest so the youngest match is the one left standing.
      for (int j = FWD_N - 1; j >= 0; j--) begin
         if (fwd_we_i[j] && (fwd_waddr_i[j*ADDR_W +: ADDR_W] == raddr_i)) begin
            data_o     = fwd_wdata_i[j*DATA_W +: DATA_W];
            load_hit_o = fwd_is_load_i[j];
         end
      end
      if (raddr_i == '0) begin
         data_o     = '0;
         load_hit_o = 1'b0;
      end
      if (!re_i) load_hit_o = 1'b0;
   end

endmodule

// File: rtl/id_stage_pipe.sv
// GeMIPS decode stage with forwarding, load-use stall, delay-slot tracking and ID/EX register.
// Optional REGIMM branches (BLTZ/BGEZ/BLTZAL/BGEZAL) are enabled by GEMIPS_ID_REGIMM_EN.
module id_stage_pipe
   import gemips_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int FWD_N  = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_W-1:0]        pc,
   input  logic [31:0]              inst,
   output logic [ADDR_W-1:0]        raddr_1,
   output logic [ADDR_W-1:0]        raddr_2,
   output logic                     re_1,
   output logic                     re_2,
   input  logic [DATA_W-1:0]        rdata_1,
   input  logic [DATA_W-1:0]        rdata_2,
   input  logic [FWD_N-1:0]         fwd_we,
   input  logic [FWD_N*ADDR_W-1:0]  fwd_waddr,
   input  logic [FWD_N*DATA_W-1:0]  fwd_wdata,
   input  logic [FWD_N-1:0]         fwd_is_load,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [7:0]               aluop,
   output logic [3:0]               alusel,
   output logic [DATA_W-1:0]        reg_1,
   output logic [DATA_W-1:0]        reg_2,
   output logic [ADDR_W-1:0]        waddr,
   output logic                     we,
   output logic [31:0]              inst_o,
   output logic [DATA_W-1:0]        link_addr_o,
   output logic                     is_in_delayslot_o,
   output logic                     branch_flag_o,
   output logic [DATA_W-1:0]        target_address_o,
   output logic [31:0]              stall_cnt_o
);

   logic [5:0] op, func;
   logic [ADDR_W-1:0] rs_a, rt_a, rd_a;
   logic [DATA_W-1:0] imm_s, imm_z, sa_z, j_tgt, b_tgt;
   assign op    = inst[31:26];
   assign func  = inst[5:0];
   assign rs_a  = ADDR_W'(inst[25:21]);
   assign rt_a  = ADDR_W'(inst[20:16]);
   assign rd_a  = ADDR_W'(inst[15:11]);
   assign imm_s = {{(DATA_W-16){inst[15]}}, inst[15:0]};
   assign imm_z = DATA_W'(inst[15:0]);
   assign sa_z  = DATA_W'(inst[10:6]);
   assign b_tgt = pc + DATA_W'(4) + {{(DATA_W-18){inst[15]}}, inst[15:0], 2'b00};
   always_comb begin
      j_tgt       = pc;
      j_tgt[27:0] = {inst[25:0], 2'b00};
   end

   logic [7:0] d_aluop;
   logic [3:0] d_alusel;
   logic d_we, d_rr, d_is_br;
   logic [ADDR_W-1:0] d_wa;
   logic [DATA_W-1:0] d_imm_1, d_imm_2, d_link;
   br_kind_e br_kind;

   always_comb begin
      d_aluop = ALU_OP_NOP;  d_alusel = ALU_SEL_NOP;
      d_we = 1'b0;  d_wa = '0;  d_rr = 1'b0;
      re_1 = 1'b0;  re_2 = 1'b0;
      d_imm_1 = '0;  d_imm_2 = '0;  d_link = '0;
      br_kind = BR_NONE;
      case (op)
         OP_SPECIAL: begin
            case (func)
               F_ADDU: begin d_aluop = ALU_OP_ADDU; d_alusel = ALU_SEL_ARITH; d_rr = 1'b1; end
               F_SUBU: begin d_aluop = ALU_OP_SUBU; d_alusel = ALU_SEL_ARITH; d_rr = 1'b1; end
               F_SLT:  begin d_aluop = ALU_OP_SLT;  d_alusel = ALU_SEL_ARITH; d_rr = 1'b1; end
               F_AND:  begin d_aluop = ALU_OP_AND;  d_alusel = ALU_SEL_LOGIC; d_rr = 1'b1; end
               F_OR:   begin d_aluop = ALU_OP_OR;   d_alusel = ALU_SEL_LOGIC; d_rr = 1'b1; end
               F_XOR:  begin d_aluop = ALU_OP_XOR;  d_alusel = ALU_SEL_LOGIC; d_rr = 1'b1; end
               F_NOR:  begin d_aluop = ALU_OP_NOR;  d_alusel = ALU_SEL_LOGIC; d_rr = 1'b1; end
               F_SLL, F_SRL: begin
                  d_aluop  = (func == F_SLL) ? ALU_OP_SLL : ALU_OP_SRL;
                  d_alusel = ALU_SEL_SHIFT;
                  re_2 = 1'b1;  d_we = 1'b1;  d_wa = rd_a;  d_imm_1 = sa_z;
               end
               F_JR: begin
                  d_aluop = ALU_OP_JR;  d_alusel = ALU_SEL_JUMP;  re_1 = 1'b1;  br_kind = BR_JR;
               end
               default: ;
            endcase
         end
         OP_SPECIAL2: if (func == F_MUL) begin
            d_aluop = ALU_OP_MUL;  d_alusel = ALU_SEL_MUL;  d_rr = 1'b1;
         end
         OP_ANDI, OP_ORI, OP_XORI: begin
            d_aluop  = (op == OP_ANDI) ? ALU_OP_AND : (op == OP_ORI) ? ALU_OP_OR : ALU_OP_XOR;
            d_alusel = ALU_SEL_LOGIC;
            re_1 = 1'b1;  d_we = 1'b1;  d_wa = rt_a;  d_imm_2 = imm_z;
         end
         OP_LUI: begin
            d_aluop = ALU_OP_LUI;  d_alusel = ALU_SEL_LOGIC;
            d_we = 1'b1;  d_wa = rt_a;  d_imm_2 = imm_z;
         end
         OP_ADDIU, OP_LB, OP_LW: begin
            d_aluop  = (op == OP_ADDIU) ? ALU_OP_ADDU : (op == OP_LB) ? ALU_OP_LB : ALU_OP_LW;
            d_alusel = (op == OP_ADDIU) ? ALU_SEL_ARITH : ALU_SEL_LOADSTORE;
            re_1 = 1'b1;  d_we = 1'b1;  d_wa = rt_a;  d_imm_2 = imm_s;
         end
         // Stores read rt as data; EX rebuilds the address offset from inst_o.
         OP_SB, OP_SW: begin
            d_aluop  = (op == OP_SB) ? ALU_OP_SB : ALU_OP_SW;
            d_alusel = ALU_SEL_LOADSTORE;
            re_1 = 1'b1;  re_2 = 1'b1;
         end
         OP_J:    begin d_aluop = ALU_OP_J; d_alusel = ALU_SEL_JUMP; br_kind = BR_J; end
         OP_JAL: begin
            d_aluop = ALU_OP_JAL;  d_alusel = ALU_SEL_JUMP;  br_kind = BR_J;
            d_we = 1'b1;  d_wa = '1;  d_link = pc + DATA_W'(8);
         end
         OP_BEQ, OP_BNE: begin
            d_aluop  = (op == OP_BEQ) ? ALU_OP_BEQ : ALU_OP_BNE;
            d_alusel = ALU_SEL_JUMP;
            re_1 = 1'b1;  re_2 = 1'b1;
            br_kind  = (op == OP_BEQ) ? BR_EQ : BR_NE;
         end
         OP_BGTZ: begin
            d_aluop = ALU_OP_BGTZ;  d_alusel = ALU_SEL_JUMP;  re_1 = 1'b1;  br_kind = BR_GTZ;
         end
`ifdef GEMIPS_ID_REGIMM_EN
         OP_REGIMM: begin
            case (inst[20:16])
               RT_BLTZ: begin
                  d_aluop = ALU_OP_BLTZ;  d_alusel = ALU_SEL_JUMP;  re_1 = 1'b1;  br_kind = BR_LTZ;
               end
               RT_BGEZ: begin
                  d_aluop = ALU_OP_BGEZ;  d_alusel = ALU_SEL_JUMP;  re_1 = 1'b1;  br_kind = BR_GEZ;
               end
               RT_BLTZAL, RT_BGEZAL: begin
                  d_aluop  = inst[16] ? ALU_OP_BGEZAL : ALU_OP_BLTZAL;
                  d_alusel = ALU_SEL_JUMP;  re_1 = 1'b1;
                  br_kind  = inst[16] ? BR_GEZ : BR_LTZ;
                  d_we = 1'b1;  d_wa = '1;  d_link = pc + DATA_W'(8);
               end
               default: ;
            endcase
         end
`endif
         default: ;
      endcase
      if (d_rr) begin
         re_1 = 1'b1;  re_2 = 1'b1;  d_we = 1'b1;  d_wa = rd_a;
      end
   end

   assign raddr_1 = rs_a;
   assign raddr_2 = rt_a;
   assign d_is_br = is_branch_op(op) || (br_kind inside {BR_JR, BR_LTZ, BR_GEZ});

   logic [DATA_W-1:0] fwd_1, fwd_2, op_1, op_2;
   logic hit_1, hit_2, hazard, acc;

   id_fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FWD_N(FWD_N)) u_fwd_1 (
      .re_i(re_1), .raddr_i(raddr_1), .rdata_i(rdata_1), .fwd_we_i(fwd_we),
      .fwd_waddr_i(fwd_waddr), .fwd_wdata_i(fwd_wdata), .fwd_is_load_i(fwd_is_load),
      .data_o(fwd_1), .load_hit_o(hit_1));
   id_fwd_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FWD_N(FWD_N)) u_fwd_2 (
      .re_i(re_2), .raddr_i(raddr_2), .rdata_i(rdata_2), .fwd_we_i(fwd_we),
      .fwd_waddr_i(fwd_waddr), .fwd_wdata_i(fwd_wdata), .fwd_is_load_i(fwd_is_load),
      .data_o(fwd_2), .load_hit_o(hit_2));

   assign op_1     = re_1 ? fwd_1 : d_imm_1;
   assign op_2     = re_2 ? fwd_2 : d_imm_2;
   assign hazard   = hit_1 | hit_2;
   // Valid/ready: a transfer happens in any cycle where in_valid and in_ready are both high.
   assign in_ready = (!out_valid || out_ready) && !hazard;
   assign acc      = in_valid && in_ready;

   logic br_taken;
   logic [DATA_W-1:0] br_tgt;
   always_comb begin
      br_taken = 1'b0;
      br_tgt   = b_tgt;
      case (br_kind)
         BR_J:    begin br_taken = 1'b1; br_tgt = j_tgt; end
         BR_JR:   begin br_taken = 1'b1; br_tgt = op_1;  end
         BR_EQ:   br_taken = (op_1 == op_2);
         BR_NE:   br_taken = (op_1 != op_2);
         BR_GTZ:  br_taken = !op_1[DATA_W-1] && (op_1 != '0);
         BR_LTZ:  br_taken = op_1[DATA_W-1];
         BR_GEZ:  br_taken = !op_1[DATA_W-1];
         default: br_taken = 1'b0;
      endcase
   end
   assign branch_flag_o    = acc && br_taken;
   assign target_address_o = branch_flag_o ? br_tgt : '0;

   logic valid_q, valid_d, we_q, we_d, ds_out_q, ds_out_d, ds_flag_q, ds_flag_d;
   logic [7:0] aluop_q, aluop_d;
   logic [3:0] alusel_q, alusel_d;
   logic [DATA_W-1:0] reg1_q, reg1_d, reg2_q, reg2_d, link_q, link_d;
   logic [ADDR_W-1:0] waddr_q, waddr_d;
   logic [31:0] inst_q, inst_d, stall_q, stall_d;

   always_comb begin
      valid_d = valid_q;   we_d = we_q;       ds_out_d = ds_out_q;  ds_flag_d = ds_flag_q;
      aluop_d = aluop_q;   alusel_d = alusel_q;
      reg1_d  = reg1_q;    reg2_d = reg2_q;   link_d = link_q;
      waddr_d = waddr_q;   inst_d = inst_q;
      stall_d = (hazard && in_valid) ? stall_q + 32'd1 : stall_q;
      if (acc) begin
         valid_d  = 1'b1;      we_d     = d_we;     waddr_d = d_wa;
         aluop_d  = d_aluop;   alusel_d = d_alusel;
         reg1_d   = op_1;      reg2_d   = op_2;     link_d  = d_link;
         inst_d   = inst;
         ds_out_d  = ds_flag_q;
         ds_flag_d = d_is_br;
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;  we_q <= 1'b0;  ds_out_q <= 1'b0;  ds_flag_q <= 1'b0;
         aluop_q <= '0;    alusel_q <= '0;
         reg1_q  <= '0;    reg2_q <= '0;  link_q <= '0;
         waddr_q <= '0;    inst_q <= '0;  stall_q <= '0;
      end else begin
         valid_q <= valid_d;  we_q <= we_d;  ds_out_q <= ds_out_d;  ds_flag_q <= ds_flag_d;
         aluop_q <= aluop_d;  alusel_q <= alusel_d;
         reg1_q  <= reg1_d;   reg2_q <= reg2_d;  link_q <= link_d;
         waddr_q <= waddr_d;  inst_q <= inst_d;  stall_q <= stall_d;
      end
   end

   assign out_valid         = valid_q;
   assign aluop             = aluop_q;
   assign alusel            = alusel_q;
   assign reg_1             = reg1_q;
   assign reg_2             = reg2_q;
   assign waddr             = waddr_q;
   assign we                = we_q;
   assign inst_o            = inst_q;
   assign link_addr_o       = link_q;
   assign is_in_delayslot_o = ds_out_q;
   assign stall_cnt_o       = stall_q;

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: a vector table for single-cycle decode/forward/branch
// behaviour, plus hand-written load-use stall, back-pressure hold and mid-hold reset sequences.
module tb_id_stage_pipe;

   logic         clk, rst, in_valid, in_ready, out_valid, out_ready;
   logic [31:0]  pc, inst, rdata_1, rdata_2;
   logic [4:0]   raddr_1, raddr_2, waddr;
   logic         re_1, re_2, we, is_in_delayslot_o, branch_flag_o;
   logic [2:0]   fwd_we, fwd_is_load;
   logic [14:0]  fwd_waddr;
   logic [95:0]  fwd_wdata;
   logic [7:0]   aluop;
   logic [3:0]   alusel;
   logic [31:0]  reg_1, reg_2, inst_o, link_addr_o, target_address_o, stall_cnt_o;

   id_stage_pipe #(.DATA_W(32), .ADDR_W(5), .FWD_N(3)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .pc(pc), .inst(inst),
      .raddr_1(raddr_1), .raddr_2(raddr_2), .re_1(re_1), .re_2(re_2),
      .rdata_1(rdata_1), .rdata_2(rdata_2), .fwd_we(fwd_we), .fwd_waddr(fwd_waddr),
      .fwd_wdata(fwd_wdata), .fwd_is_load(fwd_is_load), .out_valid(out_valid),
      .out_ready(out_ready), .aluop(aluop), .alusel(alusel), .reg_1(reg_1), .reg_2(reg_2),
      .waddr(waddr), .we(we), .inst_o(inst_o), .link_addr_o(link_addr_o),
      .is_in_delayslot_o(is_in_delayslot_o), .branch_flag_o(branch_flag_o),
      .target_address_o(target_address_o), .stall_cnt_o(stall_cnt_o));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[%0d]: got %h expected %h", nm, idx, act, exp);
      end
   endtask

   function automatic logic [31:0] rtype(input logic [4:0] rs, rt, rd, sa, input logic [5:0] fn);
      return {6'b000000, rs, rt, rd, sa, fn};
   endfunction
   function automatic logic [31:0] itype(input logic [5:0] opc, input logic [4:0] rs, rt, input logic [15:0] im);
      return {opc, rs, rt, im};
   endfunction
   function automatic logic [31:0] jtype(input logic [5:0] opc, input logic [25:0] idx);
      return {opc, idx};
   endfunction

   typedef struct {
      logic [31:0] inst, pc, rd1, rd2;
      logic [2:0]  fwe, fld;
      logic [14:0] fwa;
      logic [95:0] fwd;
      logic [31:0] e_r1, e_r2, e_link, e_tgt;
      logic [4:0]  e_wa;
      logic        e_we, e_br, e_ds, e_nop;
   } vec_t;

   function automatic vec_t mk(input logic [31:0] i, p, d1, d2, r1, r2, input logic [4:0] wa,
                               input logic w, input logic [31:0] lk, input logic br,
                               input logic [31:0] tg, input logic ds, input logic nop);
      vec_t v;
      v.inst = i;  v.pc = p;  v.rd1 = d1;  v.rd2 = d2;
      v.fwe = '0;  v.fld = '0;  v.fwa = '0;  v.fwd = '0;
      v.e_r1 = r1; v.e_r2 = r2; v.e_wa = wa; v.e_we = w; v.e_link = lk;
      v.e_br = br; v.e_tgt = tg; v.e_ds = ds; v.e_nop = nop;
      return v;
   endfunction

   task automatic drive(input vec_t v);
      inst = v.inst;  pc = v.pc;  rdata_1 = v.rd1;  rdata_2 = v.rd2;
      fwd_we = v.fwe;  fwd_is_load = v.fld;  fwd_waddr = v.fwa;  fwd_wdata = v.fwd;
      in_valid = 1'b1;
   endtask

   localparam int NV = 19;
   vec_t vecs[NV];
   logic [31:0] addu_i;

   initial begin
      rst = 1'b1;  in_valid = 1'b0;  out_ready = 1'b1;  pc = '0;  inst = '0;
      rdata_1 = '0;  rdata_2 = '0;  fwd_we = '0;  fwd_is_load = '0;  fwd_waddr = '0;  fwd_wdata = '0;

      addu_i   = rtype(5'd1, 5'd2, 5'd3, 5'd0, 6'h21);
      vecs[0]  = mk(addu_i, 32'h0, 5, 7, 5, 7, 3, 1, 0, 0, 0, 0, 0);
      vecs[1]  = mk(addu_i, 32'h4, 5, 7, 32'hAA, 7, 3, 1, 0, 0, 0, 0, 0);
      vecs[1].fwe = 3'b101;  vecs[1].fwa = {5'd1, 5'd0, 5'd1};
      vecs[1].fwd = {32'hBB, 32'h0, 32'hAA};
      vecs[2]  = mk(rtype(5'd0, 5'd2, 5'd3, 5'd0, 6'h21), 32'h8, 5, 7, 0, 7, 3, 1, 0, 0, 0, 0, 0);
      vecs[2].fwe = 3'b001;  vecs[2].fwd = {64'h0, 32'h55};
      vecs[3]  = mk(addu_i, 32'hC, 5, 7, 32'h77, 7, 3, 1, 0, 0, 0, 0, 0);
      vecs[3].fwe = 3'b011;  vecs[3].fld = 3'b010;  vecs[3].fwa = {5'd0, 5'd1, 5'd1};
      vecs[3].fwd = {32'h0, 32'h88, 32'h77};
      vecs[4]  = mk(itype(6'h0D, 5'd1, 5'd2, 16'h0001), 32'h10, 32'h10, 0, 32'h10, 1, 2, 1, 0, 0, 0, 0, 0);
      vecs[5]  = mk(itype(6'h09, 5'd1, 5'd4, 16'hFFFC), 32'h14, 3, 0, 3, 32'hFFFFFFFC, 4, 1, 0, 0, 0, 0, 0);
      vecs[6]  = mk(itype(6'h0F, 5'd0, 5'd5, 16'h8001), 32'h18, 0, 0, 0, 32'h8001, 5, 1, 0, 0, 0, 0, 0);
      vecs[7]  = mk(rtype(5'd0, 5'd2, 5'd6, 5'd3, 6'h00), 32'h1C, 0, 32'h11, 3, 32'h11, 6, 1, 0, 0, 0, 0, 0);
      vecs[8]  = mk(itype(6'h04, 5'd1, 5'd2, 16'h0004), 32'h200, 9, 9, 9, 9, 0, 0, 0, 1, 32'h214, 0, 0);
      vecs[9]  = mk(addu_i, 32'h204, 1, 2, 1, 2, 3, 1, 0, 0, 0, 1, 0);
      vecs[10] = mk(itype(6'h07, 5'd1, 5'd0, 16'h0008), 32'h400, 32'hFFFFFFFF, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 0, 0);
      vecs[11] = mk(addu_i, 32'h404, 1, 2, 1, 2, 3, 1, 0, 0, 0, 1, 0);
      vecs[12] = mk(itype(6'h05, 5'd1, 5'd2, 16'hFFFF), 32'h300, 3, 3, 3, 3, 0, 0, 0, 0, 0, 0, 0);
      vecs[13] = mk(jtype(6'h02, 26'h123), 32'h40000010, 0, 0, 0, 0, 0, 0, 0, 1, 32'h4000048C, 1, 0);
      vecs[14] = mk(jtype(6'h03, 26'h10), 32'h1000, 0, 0, 0, 0, 31, 1, 32'h1008, 1, 32'h40, 1, 0);
      vecs[15] = mk(rtype(5'd7, 5'd0, 5'd0, 5'd0, 6'h08), 32'h2000, 32'h5554, 0, 32'h5554, 0, 0, 0, 0, 1, 32'h5554, 1, 0);
      vecs[16] = mk(itype(6'h3F, 5'd0, 5'd0, 16'h1234), 32'h3000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
`ifdef GEMIPS_ID_REGIMM_EN
      vecs[17] = mk(itype(6'h01, 5'd1, 5'h11, 16'h0004), 32'h100, 0, 0, 0, 0, 31, 1, 32'h108, 1, 32'h114, 0, 0);
      vecs[18] = mk(addu_i, 32'h104, 1, 2, 1, 2, 3, 1, 0, 0, 0, 1, 0);
`else
      vecs[17] = mk(itype(6'h01, 5'd1, 5'h11, 16'h0004), 32'h100, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      vecs[18] = mk(addu_i, 32'h104, 1, 2, 1, 2, 3, 1, 0, 0, 0, 0, 0);
`endif

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_out_valid", 0, {31'b0, out_valid}, 0);
      chk("rst_reg_1", 0, reg_1, 0);
      chk("rst_we", 0, {31'b0, we}, 0);
      chk("rst_ds", 0, {31'b0, is_in_delayslot_o}, 0);
      chk("rst_stall_cnt", 0, stall_cnt_o, 0);
      chk("rst_in_ready", 0, {31'b0, in_ready}, 1);

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         drive(vecs[i]);
         #1;
         chk("in_ready", i, {31'b0, in_ready}, 1);
         chk("branch_flag", i, {31'b0, branch_flag_o}, {31'b0, vecs[i].e_br});
         chk("target", i, target_address_o, vecs[i].e_tgt);
         @(posedge clk);
         #1;
         chk("out_valid", i, {31'b0, out_valid}, 1);
         chk("reg_1", i, reg_1, vecs[i].e_r1);
         chk("reg_2", i, reg_2, vecs[i].e_r2);
         chk("waddr", i, {27'b0, waddr}, {27'b0, vecs[i].e_wa});
         chk("we", i, {31'b0, we}, {31'b0, vecs[i].e_we});
         chk("link", i, link_addr_o, vecs[i].e_link);
         chk("delayslot", i, {31'b0, is_in_delayslot_o}, {31'b0, vecs[i].e_ds});
         chk("inst_o", i, inst_o, vecs[i].inst);
         chk("aluop_nop", i, {31'b0, (aluop == 8'h00)}, {31'b0, vecs[i].e_nop});
      end

      // Load-use: youngest source is a load on r1 while ORI r2,r1,1 waits.
      @(negedge clk);
      inst = itype(6'h0D, 5'd1, 5'd2, 16'h0001);  pc = 32'h500;  rdata_1 = 32'h20;  rdata_2 = 0;
      fwd_we = 3'b001;  fwd_waddr = {5'd0, 5'd0, 5'd1};  fwd_wdata = '0;  fwd_is_load = 3'b001;
      in_valid = 1'b1;
      #1 chk("stall_in_ready", 0, {31'b0, in_ready}, 0);
      @(posedge clk); #1;
      chk("stall_cnt", 0, stall_cnt_o, 1);
      chk("stall_bubble", 0, {31'b0, out_valid}, 0);
      @(negedge clk);
      fwd_we = '0;  fwd_is_load = '0;
      #1 chk("stall_in_ready", 1, {31'b0, in_ready}, 1);
      @(posedge clk); #1;
      chk("stall_out_valid", 1, {31'b0, out_valid}, 1);
      chk("stall_reg_1", 1, reg_1, 32'h20);
      chk("stall_reg_2", 1, reg_2, 1);
      chk("stall_cnt", 1, stall_cnt_o, 1);

      // Back-pressure hold for three cycles, then reset while holding.
      @(negedge clk);
      inst = addu_i;  rdata_1 = 5;  rdata_2 = 7;  out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;  inst = itype(6'h0D, 5'd1, 5'd2, 16'h0001);  rdata_1 = 32'h99;
      #1 chk("hold_in_ready", 0, {31'b0, in_ready}, 0);
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         chk("hold_out_valid", k, {31'b0, out_valid}, 1);
         chk("hold_reg_1", k, reg_1, 5);
         chk("hold_reg_2", k, reg_2, 7);
         chk("hold_waddr", k, {27'b0, waddr}, 3);
      end
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("hold_rst_out_valid", 0, {31'b0, out_valid}, 0);
      chk("hold_rst_stall_cnt", 0, stall_cnt_o, 0);
      chk("hold_rst_reg_1", 0, reg_1, 0);
      @(negedge clk);
      rst = 1'b0;  in_valid = 1'b0;  out_ready = 1'b1;
      @(posedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
